// File: rtl/sys_arr_out_deskew.sv
// rtl/sys_arr_out_deskew.sv - realigns staggered systolic-array column outputs into full rows
// and writes them to the output buffer, framed by a start/done batch handshake.
module sys_arr_out_deskew #(
    parameter int width_height = 2,
    parameter int addr_width   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [16*width_height-1:0] maccin,
    input  logic [width_height-1:0]    activein,
    input  logic                       start,
    input  logic [addr_width-1:0]      base_addr,
    input  logic [addr_width-1:0]      num_rows,
    output logic                       wr_en,
    output logic [addr_width-1:0]      wr_addr,
    output logic [16*width_height-1:0] wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

    logic [16*width_height-1:0] w_al_data;
    logic [width_height-1:0]    w_al_vld;
    logic                       w_row_valid;
    logic                       w_misalign;

    // Column c waits width_height-1-c cycles so it meets the rightmost column.
    genvar c;
    generate
        for (c = 0; c < width_height; c++) begin : g_col
            localparam int DEPTH = width_height - 1 - c;
            if (DEPTH == 0) begin : g_pass
                assign w_al_data[16*c +: 16] = maccin[16*c +: 16];
                assign w_al_vld[c]           = activein[c];
            end else begin : g_dly
                logic [15:0] r_d [DEPTH];
                logic        r_v [DEPTH];
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_d[i] <= '0;
                            r_v[i] <= 1'b0;
                        end
                    end else begin
                        r_d[0] <= maccin[16*c +: 16];
                        r_v[0] <= activein[c];
                        for (int i = 1; i < DEPTH; i++) begin
                            r_d[i] <= r_d[i-1];
                            r_v[i] <= r_v[i-1];
                        end
                    end
                end
                assign w_al_data[16*c +: 16] = r_d[DEPTH-1];
                assign w_al_vld[c]           = r_v[DEPTH-1];
            end
        end
    endgenerate

    assign w_row_valid = &w_al_vld;
    assign w_misalign  = (|w_al_vld) && !w_row_valid;

    state_t                     r_state, w_state_nxt;
    logic [addr_width-1:0]      r_addr, w_addr_nxt;
    logic [addr_width-1:0]      r_num, w_num_nxt;
    logic [addr_width-1:0]      r_cnt, w_cnt_nxt;
    logic                       r_wr_en, w_wr_en_nxt;
    logic [16*width_height-1:0] r_wr_data, w_wr_data_nxt;
    logic                       r_err, w_err_nxt;

    // r_cnt counts accepted rows; the batch ends on the write of the last accepted row.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_wr_en ? r_addr + ADDR_ONE : r_addr;
        w_num_nxt     = r_num;
        w_cnt_nxt     = r_cnt;
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = r_wr_data;
        w_err_nxt     = r_err | w_misalign;
        case (r_state)
            S_IDLE: begin
                if (w_row_valid) begin
                    w_err_nxt = 1'b1;
                end
                if (start) begin
                    w_addr_nxt  = base_addr;
                    w_num_nxt   = num_rows;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = w_misalign | w_row_valid;
                    w_state_nxt = (num_rows == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_row_valid) begin
                    if (r_cnt != r_num) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_data_nxt = w_al_data;
                        w_cnt_nxt     = r_cnt + ADDR_ONE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (r_wr_en && (r_cnt == r_num)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_row_valid) begin
                    w_err_nxt = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_num     <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_num     <= w_num_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
endmodule

// File: tb/tb_sys_arr_out_deskew.sv
// tb/tb_sys_arr_out_deskew.sv - scoreboard bench for sys_arr_out_deskew (2x2 array, 8-bit addresses).
module tb_sys_arr_out_deskew;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] maccin = '0;
    logic [1:0]  activein = '0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  num_rows = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;

    sys_arr_out_deskew #(.width_height(2), .addr_width(8)) dut (
        .clk(clk), .reset(reset), .maccin(maccin), .activein(activein),
        .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cy;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int last_wr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected row, address and cycle.
    always @(negedge clk) begin
        if (!reset && wr_en === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", {56'h0, wr_addr}, {56'h0, e.addr});
                chk("wr_data", {32'h0, wr_data}, {32'h0, e.data});
                chk("wr_cycle", 64'(cyc), 64'(e.cy));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        tick();
        start = 1'b1;
        base_addr = b;
        num_rows = n;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // Column 0 of row i in cycle c+i, column 1 one cycle later; the first nexp rows are expected written.
    task automatic send_rows(input int n, input logic [15:0] d0 [4], input logic [15:0] d1 [4],
                             input int nexp, input logic [7:0] base);
        for (int i = 0; i <= n; i++) begin
            tick();
            activein[0]    = (i < n);
            maccin[15:0]   = (i < n) ? d0[i] : 16'h0;
            activein[1]    = (i >= 1);
            maccin[31:16]  = (i >= 1) ? d1[i-1] : 16'h0;
            if (i < nexp) begin
                q.push_back('{8'(base + 8'(i)), {d1[i], d0[i]}, cyc + 2});
                last_wr = cyc + 2;
            end
        end
        tick();
        activein = '0;
        maccin = '0;
    endtask

    task automatic wait_done(input string name, input int exp_cy);
        bit seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_cy));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual no done required done at cycle %0d", name, exp_cy);
        end else begin
            @(negedge clk);
            chk({name, "_done_width"}, {63'h0, done}, 64'h0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_wr_en", {63'h0, wr_en}, 64'h0);
        chk("rst_wr_addr", {56'h0, wr_addr}, 64'h0);
        chk("rst_wr_data", {32'h0, wr_data}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        reset = 1'b0;
        repeat (4) tick();

        // Basic batch
        do_start(8'h10, 8'd2);
        chk("basic_busy", {63'h0, busy}, 64'h1);
        send_rows(2, '{16'h0001, 16'h0003, 16'h0, 16'h0}, '{16'h0002, 16'h0004, 16'h0, 16'h0}, 2, 8'h10);
        wait_done("basic", last_wr + 1);
        chk("basic_err", {63'h0, err}, 64'h0);
        chk("basic_idle", {63'h0, busy}, 64'h0);

        // Address wrap
        do_start(8'hFF, 8'd2);
        send_rows(2, '{16'hAAAA, 16'h1234, 16'h0, 16'h0}, '{16'h5555, 16'hBEEF, 16'h0, 16'h0}, 2, 8'hFF);
        wait_done("wrap", last_wr + 1);

        // Misalignment: column 0 alone
        tick();
        activein = 2'b01;
        maccin = 32'h0000_0077;
        tick();
        activein = '0;
        maccin = '0;
        tick();
        tick();
        chk("misalign_err", {63'h0, err}, 64'h1);

        // num_rows = 0 clears err and finishes next cycle
        do_start(8'h50, 8'd0);
        wait_done("zero_rows", start_cyc + 1);
        chk("zero_rows_err_cleared", {63'h0, err}, 64'h0);

        // Row with no start
        send_rows(1, '{16'h0011, 16'h0, 16'h0, 16'h0}, '{16'h0022, 16'h0, 16'h0, 16'h0}, 0, 8'h00);
        tick();
        chk("idle_row_err", {63'h0, err}, 64'h1);

        // Extra row
        do_start(8'h30, 8'd1);
        chk("extra_err_cleared", {63'h0, err}, 64'h0);
        send_rows(2, '{16'h0005, 16'h0007, 16'h0, 16'h0}, '{16'h0006, 16'h0008, 16'h0, 16'h0}, 1, 8'h30);
        wait_done("extra", last_wr + 1);
        chk("extra_err", {63'h0, err}, 64'h1);

        // Start while busy is ignored
        do_start(8'h40, 8'd2);
        start = 1'b1;
        base_addr = 8'h80;
        num_rows = 8'd5;
        tick();
        start = 1'b0;
        send_rows(2, '{16'hC001, 16'hC003, 16'h0, 16'h0}, '{16'hC002, 16'hC004, 16'h0, 16'h0}, 2, 8'h40);
        wait_done("busy_start", last_wr + 1);
        chk("busy_start_err", {63'h0, err}, 64'h0);

        // Reset mid-batch during a write
        do_start(8'h20, 8'd2);
        tick();
        activein = 2'b01;
        maccin = 32'h0000_0009;
        tick();
        activein = 2'b11;
        maccin = 32'h000A_000B;
        tick();
        #2;
        reset = 1'b1;
        activein = '0;
        maccin = '0;
        #1;
        chk("midrst_wr_en", {63'h0, wr_en}, 64'h0);
        chk("midrst_wr_addr", {56'h0, wr_addr}, 64'h0);
        chk("midrst_wr_data", {32'h0, wr_data}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("post_rst_busy", {63'h0, busy}, 64'h0);
        chk("post_rst_err", {63'h0, err}, 64'h0);

        chk("scoreboard_empty", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
